// File: rtl/cla_pkg.sv
// Shared constants and helpers for the pipelined lookahead adder/subtractor.
package cla_pkg;

  localparam logic MODE_ADD = 1'b0;
  localparam logic MODE_SUB = 1'b1;

  // A non-positive block size is reported separately by the top-level check.
  function automatic int calc_stages(input int width, input int block);
    return (block < 1) ? 1 : width / block;
  endfunction

endpackage

// File: rtl/cla_block.sv
// One BLOCK-bit carry-lookahead slice.
// Every carry is a flat sum of products of g and p terms, so the carries do not ripple inside the slice.
module cla_block #(
  parameter int BLOCK = 8
) (
  input  logic [BLOCK-1:0] a,
  input  logic [BLOCK-1:0] b,
  input  logic             ci,
  output logic [BLOCK-1:0] s,
  output logic             co,
  output logic             c_msb
);

  logic [BLOCK-1:0] w_p;
  logic [BLOCK-1:0] w_g;
  logic [BLOCK:0]   w_c;

  assign w_p = a ^ b;
  assign w_g = a & b;

  // c[i] = g[i-1] | p[i-1]g[i-2] | ... | p[i-1..0]ci
  always_comb begin : b_lookahead
    logic v_pp;
    logic v_c;
    w_c  = '0;
    v_pp = 1'b1;
    v_c  = 1'b0;
    for (int i = 0; i <= BLOCK; i++) begin
      v_pp = 1'b1;
      v_c  = 1'b0;
      for (int j = i - 1; j >= 0; j--) begin
        v_c  = v_c | (v_pp & w_g[j]);
        v_pp = v_pp & w_p[j];
      end
      w_c[i] = v_c | (v_pp & ci);
    end
  end

  assign s     = w_p ^ w_c[BLOCK-1:0];
  assign co    = w_c[BLOCK];
  assign c_msb = w_c[BLOCK-1];

endmodule

// File: rtl/cla_addsub_pipe.sv
// Pipelined carry-lookahead adder/subtractor. It resolves one BLOCK-bit slice per stage and
// uses a valid/ready handshake; a single global stall holds every stage.
module cla_addsub_pipe
  import cla_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int BLOCK = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf,
  output logic             zero
);

  localparam int BLK_SAFE = (BLOCK < 1) ? 1 : BLOCK;
  localparam int STAGES   = calc_stages(WIDTH, BLOCK);

  generate
    if (BLOCK < 1 || (WIDTH % BLK_SAFE) != 0) begin : g_param_err
      $error("cla_addsub_pipe: WIDTH must be a positive multiple of BLOCK");
    end
  endgenerate

  logic             w_adv;

  logic [WIDTH-1:0] w_a_in   [STAGES];
  logic [WIDTH-1:0] w_b_in   [STAGES];
  logic [WIDTH-1:0] w_s_in   [STAGES];
  logic [WIDTH-1:0] w_s_nxt  [STAGES];
  logic [BLOCK-1:0] w_blk_s  [STAGES];
  logic             w_c_in   [STAGES];
  logic             w_v_in   [STAGES];
  logic             w_sub_in [STAGES];
  logic             w_co     [STAGES];
  logic             w_cmsb   [STAGES];

  logic [WIDTH-1:0] r_a   [STAGES];
  logic [WIDTH-1:0] r_b   [STAGES];
  logic [WIDTH-1:0] r_s   [STAGES];
  logic             r_c   [STAGES];
  logic             r_vld [STAGES];
  logic             r_sub [STAGES];
  logic             r_ovf;
  logic             r_zero;

  assign w_adv    = ~r_vld[STAGES-1] | out_ready;
  assign in_ready = w_adv;

  generate
    for (genvar k = 0; k < STAGES; k++) begin : g_stage
      if (k == 0) begin : g_first
        // The B operand is inverted once here and then travels down the pipe already inverted.
        assign w_a_in[k]   = a;
        assign w_b_in[k]   = b ^ {WIDTH{sub}};
        assign w_c_in[k]   = (sub == MODE_SUB) ? 1'b1 : cin;
        assign w_v_in[k]   = in_valid;
        assign w_sub_in[k] = sub;
        assign w_s_in[k]   = '0;
      end else begin : g_next
        assign w_a_in[k]   = r_a[k-1];
        assign w_b_in[k]   = r_b[k-1];
        assign w_c_in[k]   = r_c[k-1];
        assign w_v_in[k]   = r_vld[k-1];
        assign w_sub_in[k] = r_sub[k-1];
        assign w_s_in[k]   = r_s[k-1];
      end

      cla_block #(
        .BLOCK(BLOCK)
      ) u_blk (
        .a    (w_a_in[k][k*BLOCK +: BLOCK]),
        .b    (w_b_in[k][k*BLOCK +: BLOCK]),
        .ci   (w_c_in[k]),
        .s    (w_blk_s[k]),
        .co   (w_co[k]),
        .c_msb(w_cmsb[k])
      );

      // The bits above slice k are still zero at this point, so an OR places the new slice.
      assign w_s_nxt[k] = w_s_in[k] | (WIDTH'(w_blk_s[k]) << (k * BLOCK));
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < STAGES; k++) begin
        r_a[k]   <= '0;
        r_b[k]   <= '0;
        r_s[k]   <= '0;
        r_c[k]   <= 1'b0;
        r_vld[k] <= 1'b0;
        r_sub[k] <= MODE_ADD;
      end
      r_ovf  <= 1'b0;
      r_zero <= 1'b0;
    end else if (w_adv) begin
      for (int k = 0; k < STAGES; k++) begin
        r_a[k]   <= w_a_in[k];
        r_b[k]   <= w_b_in[k];
        r_s[k]   <= w_s_nxt[k];
        r_c[k]   <= w_co[k];
        r_vld[k] <= w_v_in[k];
        r_sub[k] <= w_sub_in[k];
      end
      r_ovf  <= w_cmsb[STAGES-1] ^ w_co[STAGES-1];
      r_zero <= ~|w_s_nxt[STAGES-1];
    end
  end

  assign out_valid = r_vld[STAGES-1];
  assign sum       = r_s[STAGES-1];
  assign cout      = r_c[STAGES-1];
  assign ovf       = r_ovf;
  assign zero      = r_zero;

endmodule
